// File: rtl/serial_sub_unit.sv
// Multi-cycle unsigned subtractor: computes a - b - bin over WIDTH bits, DIGIT bits per clock,
// LSB first, with a start/busy/done handshake.
module serial_sub_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             br_q;
    logic [CW-1:0]    count_q;

    logic [DIGIT-1:0] dig;
    logic             br_out;
    logic [WIDTH-1:0] res_next;

    // Ripple the borrow through DIGIT full-subtractor cells.
    always_comb begin
        logic c;
        c   = br_q;
        dig = '0;
        for (int i = 0; i < DIGIT; i++) begin
            dig[i] = a_q[i] ^ b_q[i] ^ c;
            c      = (~a_q[i] & b_q[i]) | (c & ~(a_q[i] ^ b_q[i]));
        end
        br_out   = c;
        res_next = (res_q >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            count_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            zero    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= bin;
                        res_q   <= '0;
                        count_q <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    br_q    <= br_out;
                    res_q   <= res_next;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(STEPS - 1)) begin
                        diff    <= res_next;
                        bout    <= br_out;
                        zero    <= (res_next == '0);
                        done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_unit.sv
// Directed and random checks of serial_sub_unit at DIGIT = 1, 4 and 8 (WIDTH = 8).
module tb_serial_sub_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start4, start8;
    logic [7:0] a, b;
    logic       bin;

    logic       busy1, done1, bout1, zero1;
    logic       busy4, done4, bout4, zero4;
    logic       busy8, done8, bout8, zero8;
    logic [7:0] diff1, diff4, diff8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_sub_unit #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .bin(bin),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .zero(zero1)
    );

    serial_sub_unit #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .bin(bin),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4)
    );

    serial_sub_unit #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst(rst), .start(start8), .a(a), .b(b), .bin(bin),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start an op on the DIGIT=1 unit; edges counts the start edge too.
    task automatic op1(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                       output int edges);
        a = ia; b = ib; bin = ibin; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        edges = 1;
        while (!done1 && edges < 20) begin
            tick();
            edges++;
        end
        if (!done1) begin
            n_checks++; n_fail++;
            $display("FAIL op1_timeout: done never rose within %0d edges", edges);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start1 = 1'b0; start4 = 1'b0; start8 = 1'b0;
        a = 8'h00; b = 8'h00; bin = 1'b0;
        tick(); tick();
        n_checks++;
        if ({busy1, done1, diff1, bout1, zero1} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_d1: got busy=%b done=%b diff=%h bout=%b zero=%b, want all 0",
                     busy1, done1, diff1, bout1, zero1);
        end
        n_checks++;
        if ({busy4, done4, diff4, busy8, done8, diff8} !== 20'h00000) begin
            n_fail++;
            $display("FAIL reset_d4_d8: got busy4=%b diff4=%h busy8=%b diff8=%h, want 0",
                     busy4, diff4, busy8, diff8);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_vectors();
        logic [7:0] va   [4] = '{8'h35, 8'h00, 8'h10, 8'hFF};
        logic [7:0] vb   [4] = '{8'h12, 8'h01, 8'h0F, 8'hFF};
        logic       vbin [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] vd   [4] = '{8'h23, 8'hFF, 8'h00, 8'hFF};
        logic       vbo  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic       vz   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int e;
        for (int i = 0; i < 4; i++) begin
            op1(va[i], vb[i], vbin[i], e);
            n_checks++;
            if (e !== 9) begin
                n_fail++;
                $display("FAIL vec%0d_latency: got %0d edges, want 9", i, e);
            end
            n_checks++;
            if ({bout1, diff1, zero1} !== {vbo[i], vd[i], vz[i]}) begin
                n_fail++;
                $display("FAIL vec%0d_result: got bout=%b diff=%h zero=%b, want %b %h %b",
                         i, bout1, diff1, zero1, vbo[i], vd[i], vz[i]);
            end
            a = 8'hAA; b = 8'h55;
            tick();
            n_checks++;
            if ({busy1, done1} !== 2'b00 || diff1 !== vd[i]) begin
                n_fail++;
                $display("FAIL vec%0d_after: got busy=%b done=%b diff=%h, want 0 0 %h",
                         i, busy1, done1, diff1, vd[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int pulses = 0;
        logic [7:0] got = 8'h00;
        a = 8'h35; b = 8'h12; bin = 1'b0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n_checks++;
        if (busy1 !== 1'b1 || diff1 !== 8'hFF) begin
            n_fail++;
            $display("FAIL ign_run1: got busy=%b diff=%h, want 1 ff", busy1, diff1);
        end
        tick(); tick();
        a = 8'h99; b = 8'h01; bin = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (done1) begin
                pulses++;
                got = diff1;
            end
            tick();
        end
        n_checks++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL ign_pulses: got %0d done pulses, want 1", pulses);
        end
        n_checks++;
        if (got !== 8'h23) begin
            n_fail++;
            $display("FAIL ign_result: got diff=%h, want 23", got);
        end
    endtask

    task automatic test_abort();
        int pulses = 0;
        int e;
        a = 8'h80; b = 8'h01; bin = 1'b0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({busy1, done1, diff1, bout1, zero1} !== 12'h000) begin
            n_fail++;
            $display("FAIL abort_state: got busy=%b done=%b diff=%h bout=%b zero=%b, want 0",
                     busy1, done1, diff1, bout1, zero1);
        end
        for (int i = 0; i < 12; i++) begin
            if (done1) pulses++;
            tick();
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL abort_nodone: got %0d done pulses, want 0", pulses);
        end
        op1(8'h80, 8'h01, 1'b0, e);
        n_checks++;
        if (e !== 9 || {bout1, diff1, zero1} !== {1'b0, 8'h7F, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_restart: got edges=%0d bout=%b diff=%h zero=%b, want 9 0 7f 0",
                     e, bout1, diff1, zero1);
        end
        tick();
    endtask

    task automatic test_rst_start_same();
        int pulses = 0;
        a = 8'h05; b = 8'h01; bin = 1'b0;
        rst = 1'b1; start1 = 1'b1;
        tick();
        rst = 1'b0; start1 = 1'b0;
        n_checks++;
        if (busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_start_busy: got busy=%b, want 0", busy1);
        end
        for (int i = 0; i < 12; i++) begin
            if (done1 || busy1) pulses++;
            tick();
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL rst_start_idle: got %0d active cycles, want 0", pulses);
        end
    endtask

    task automatic test_random_d4();
        logic [8:0] g;
        int e;
        for (int n = 0; n < 1000; n++) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            g = {1'b0, a} - {1'b0, b} - 9'(bin);
            start4 = 1'b1;
            tick();
            start4 = 1'b0;
            e = 1;
            while (!done4 && e < 10) begin
                tick();
                e++;
            end
            n_checks++;
            if (!done4 || e !== 3) begin
                n_fail++;
                $display("FAIL d4_latency op%0d: got done=%b edges=%0d, want 1 3", n, done4, e);
            end
            n_checks++;
            if ({bout4, diff4} !== g || zero4 !== (g[7:0] == 8'h00)) begin
                n_fail++;
                $display("FAIL d4_result op%0d: got bout=%b diff=%h zero=%b, want %b %h",
                         n, bout4, diff4, zero4, g[8], g[7:0]);
            end
            tick();
        end
    endtask

    task automatic test_random_d8();
        logic [8:0] g;
        int e;
        for (int n = 0; n < 1000; n++) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            g = {1'b0, a} - {1'b0, b} - 9'(bin);
            start8 = 1'b1;
            tick();
            start8 = 1'b0;
            e = 1;
            while (!done8 && e < 10) begin
                tick();
                e++;
            end
            n_checks++;
            if (!done8 || e !== 2) begin
                n_fail++;
                $display("FAIL d8_latency op%0d: got done=%b edges=%0d, want 1 2", n, done8, e);
            end
            n_checks++;
            if ({bout8, diff8} !== g || zero8 !== (g[7:0] == 8'h00)) begin
                n_fail++;
                $display("FAIL d8_result op%0d: got bout=%b diff=%h zero=%b, want %b %h",
                         n, bout8, diff8, zero8, g[8], g[7:0]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_ignore_start();
        test_abort();
        test_rst_start_same();
        test_random_d4();
        test_random_d8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
